// File: rtl/lsu_mem_master.sv
// lsu_mem_master: byte-addressed load/store initiator for a word-organised,
// combinationally-read data memory. Sub-word stores are done as
// read-modify-write. Sub-word loads are sign/zero extended. One response per request.
module lsu_mem_master #(
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_dst,
    output logic [31:0] mem_value,
    output logic        mem_esc,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        f3_ok;
    logic        align_ok;
    logic        range_ok;
    logic        legal;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Width code must be a listed load/store encoding; 100/101 only exist for loads.
    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
    end

    // Natural alignment: halfwords on even bytes, words on 4-byte boundaries.
    always_comb begin
        align_ok = 1'b1;
        case (req_funct3[1:0])
            2'b01:   align_ok = !req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    // Byte address must fall inside the 2^ADDR_W word memory.
    assign range_ok = ((req_addr >> (ADDR_W + 2)) == 32'd0);
    assign legal    = f3_ok && align_ok && range_ok;

    // Little-endian lane extraction from the live read data, then extension.
    assign shifted = mem_rdata >> {off_q, 3'b000};

    // Sign-extend lb/lh, zero-extend lbu/lhu; lw passes the word through.
    always_comb begin
        load_val = shifted;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Splice the store data into the captured word; sw replaces it outright.
    always_comb begin
        merged = word_q;
        case (f3_q[1:0])
            2'b00:   merged[{off_q, 3'b000} +: 8]       = wdata_q[7:0];
            2'b01:   merged[{off_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Transaction sequencing, request capture and registered response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            wdata_q   <= 32'd0;
            word_q    <= 32'd0;
            mem_dst   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        if (legal) begin
                            // Word address must be stable during READ for the combinational read.
                            mem_dst <= 32'(req_addr[ADDR_W+1:2]);
                            state   <= READ;
                        end else begin
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                READ: begin
                    word_q <= mem_rdata;
                    if (we_q) begin
                        state <= WRITE;
                    end else begin
                        rsp_rdata <= load_val;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake/strobe outputs decode straight from state, so reset clears
    // the write enable immediately without waiting for a clock edge.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign mem_esc   = (state == WRITE);
    assign mem_value = mem_esc ? merged : 32'd0;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master against a byte-level reference model.
module tb_lsu_mem_master;

    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_dst;
    logic [31:0] mem_value;
    logic        mem_esc;
    logic [31:0] mem_rdata;

    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        mem_init_done = 1'b0;

    int          passed = 0;
    int          total = 0;
    logic [31:0] last_rd;

    lsu_mem_master #(.ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_dst(mem_dst), .mem_value(mem_value), .mem_esc(mem_esc),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Data memory: combinational read, clocked write.
    assign mem_rdata = mem[mem_dst[AW-1:0]];
    always @(posedge clock) begin
        if (!mem_init_done) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (mem_esc) begin
            mem[mem_dst[AW-1:0]] <= mem_value;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        int sz;
        case (f3)
            3'd0, 3'd1, 3'd2: ok = 1'b1;
            3'd4, 3'd5:       ok = !we;
            default:          ok = 1'b0;
        endcase
        sz = 1 << f3[1:0];
        return ok && ((a % sz) == 0) && (a < 4 * DEPTH);
    endfunction

    // Behavioural effect of one request: byte-wise store, shift/mask/extend load.
    task automatic ref_exec(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output bit err, output logic [31:0] rd);
        int sz, idx, sh;
        logic [31:0] w, mask, v;
        rd = 32'd0;
        err = !ref_legal(we, f3, a);
        if (err) return;
        sz  = 1 << f3[1:0];
        idx = int'(a / 4);
        sh  = 8 * int'(a % 4);
        if (we) begin
            w = ref_mem[idx];
            for (int i = 0; i < sz; i++) begin
                w = w & ~(32'hFF << (sh + 8 * i));
                w = w | (((wd >> (8 * i)) & 32'hFF) << (sh + 8 * i));
            end
            ref_mem[idx] = w;
        end else begin
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            v = (ref_mem[idx] >> sh) & mask;
            if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
            rd = v;
        end
    endtask

    task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        bit          eerr;
        logic [31:0] erd;
        int          lat, esc_n, n, exp_lat;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clock);
        ref_exec(we, f3, a, wd, eerr, erd);
        #1;
        // Busy-time inputs are garbage and must be ignored.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0;
        esc_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (k == 1) chk("ready_low", 32'(req_ready), 32'd0);
            if (mem_esc) begin
                esc_n++;
                chk("esc_dst", mem_dst, a >> 2);
            end else begin
                chk("value_idle", mem_value, 32'd0);
            end
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
        exp_lat = eerr ? 1 : (we ? 3 : 2);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("rsp_rdata", rsp_rdata, erd);
        chk("esc_count", 32'(esc_n), (!eerr && we) ? 32'd1 : 32'd0);
        last_rd = rsp_rdata;
        @(negedge clock);
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          we;
        logic [2:0]  f3;
        logic [31:0] a;
        int          r;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
        @(negedge clock);
        mem_init_done = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_dst", mem_dst, 32'd0);
        reset_n = 1'b1;

        // Word round trip.
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("plan_lw", last_rd, 32'hDEADBEEF);
        // Byte read-modify-write.
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h11, 32'h000000AA);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("plan_sb_word", last_rd, 32'h1122AA44);
        do_req(1'b0, 3'b000, 32'h11, 32'h0);
        chk("plan_lb", last_rd, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h11, 32'h0);
        chk("plan_lbu", last_rd, 32'h000000AA);
        // Halfword.
        do_req(1'b1, 3'b010, 32'h10, 32'h11223344);
        do_req(1'b1, 3'b001, 32'h12, 32'h00008001);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("plan_sh_word", last_rd, 32'h80013344);
        do_req(1'b0, 3'b001, 32'h12, 32'h0);
        chk("plan_lh", last_rd, 32'hFFFF8001);
        do_req(1'b0, 3'b101, 32'h12, 32'h0);
        chk("plan_lhu", last_rd, 32'h00008001);

        // Asynchronous reset mid-cycle: outputs clear before any edge.
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_ready", 32'(req_ready), 32'd1);
        chk("arst_valid", 32'(rsp_valid), 32'd0);
        chk("arst_rdata", rsp_rdata, 32'd0);
        chk("arst_err", 32'(rsp_err), 32'd0);
        chk("arst_esc", 32'(mem_esc), 32'd0);
        chk("arst_value", mem_value, 32'd0);
        chk("arst_dst", mem_dst, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Illegal requests.
        do_req(1'b0, 3'b010, 32'h02, 32'h0);
        chk("plan_err_lw2", last_rd, 32'h0);
        do_req(1'b1, 3'b001, 32'h01, 32'h1234);
        do_req(1'b0, 3'b010, 32'h400, 32'h0);
        do_req(1'b1, 3'b100, 32'h10, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("plan_err_unchanged", last_rd, 32'h80013344);

        // Reset while in WRITE: the store must not commit and no response appears.
        @(negedge clock);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h5A5A5A5A;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("wr_esc_high", 32'(mem_esc), 32'd1);
        #1 reset_n = 1'b0;
        #1 chk("wr_rst_esc", 32'(mem_esc), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("wr_rst_norsp", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b1;
        do_req(1'b0, 3'b010, 32'h20, 32'h0);

        // Random traffic, biased towards aligned in-range accesses.
        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            r  = int'($urandom_range(0, 9));
            if (r == 0) a = $urandom;
            else a = 32'($urandom_range(0, 4 * DEPTH - 1));
            if (r >= 3) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
            do_req(we, f3, a, $urandom);
        end

        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
